rr_mux_arb: RTL and testbench

RR_MUX_ARB -- requirements
Module: rr_mux_arb

---
 rtl/mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/rr_mux_arb.sv | 91 +++++++++
 tb/tb_rr_mux_arb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin mux/arbiter.
`timescale 1ns/1ps
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority grant: first requester at or after ptr, wrapping modulo NCH.
`timescale 1ns/1ps
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NCH  = 8,
    parameter int SELW = clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] idx,
    output logic            any,
    output logic [SELW-1:0] ptr_nxt
);

    int k;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        for (int i = 0; i < NCH; i++) begin
            k = int'(ptr) + i;
            if (k >= NCH) k = k - NCH;
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = k[SELW-1:0];
            end
        end
        // Next pointer is the channel after the winner, wrapping at NCH-1.
        ptr_nxt = (int'(idx) == NCH - 1) ? '0 : idx + SELW'(1);
    end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel to 1 mux with fixed or round-robin selection and a registered output stage.
`timescale 1ns/1ps
module rr_mux_arb
    import mux_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  NCH   = 8,
    localparam int SELW  = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
);

    logic            load;
    logic            xfer;
    logic            grant_any;
    logic            fix_any;
    logic            rr_any;
    logic [NCH-1:0]  fix_gnt;
    logic [NCH-1:0]  rr_gnt;
    logic [NCH-1:0]  gnt;
    logic [SELW-1:0] g;
    logic [SELW-1:0] rr_idx;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_nxt;

    // A sel value at or beyond NCH matches no channel, so nothing is granted.
    always_comb begin
        fix_gnt = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) fix_gnt[k] = in_valid[k];
        end
    end

    assign fix_any = |fix_gnt;

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (rr_gnt),
        .idx     (rr_idx),
        .any     (rr_any),
        .ptr_nxt (ptr_nxt)
    );

    // Handshake: a channel transfers when in_valid[k] && in_ready[k] at a rising
    // edge; the output transfers when out_valid && out_ready. in_ready is held low
    // during reset and whenever the output register cannot load.
    always_comb begin
        load      = !out_valid || out_ready;
        gnt       = fix_gnt;
        g         = sel;
        grant_any = fix_any;
        if (mode == MODE_RR) begin
            gnt       = rr_gnt;
            g         = rr_idx;
            grant_any = rr_any;
        end
        xfer     = grant_any && load && rst_n;
        in_ready = (load && rst_n) ? gnt : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (load) out_valid <= xfer;
            if (xfer) begin
                out_data <= in_data[int'(g)*WIDTH +: WIDTH];
                out_ch   <= g;
            end
            if (xfer && mode == MODE_RR) ptr <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed checks of rr_mux_arb plus a randomised scoreboard sweep at two sizes.
`timescale 1ns/1ps
module tb_rr_mux_arb;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 8x8 main instance
    logic        mode8, out_valid8, out_ready8;
    logic [2:0]  sel8, out_ch8;
    logic [63:0] in_data8;
    logic [7:0]  in_valid8, in_ready8, out_data8;

    // WIDTH=8, NCH=6 instance for out-of-range sel
    logic        mode6, out_valid6, out_ready6;
    logic [2:0]  sel6, out_ch6;
    logic [47:0] in_data6;
    logic [5:0]  in_valid6, in_ready6;
    logic [7:0]  out_data6;

    // WIDTH=1, NCH=2 instance
    logic        mode2, out_valid2, out_ready2;
    logic [0:0]  sel2, out_ch2, out_data2;
    logic [1:0]  in_data2, in_valid2, in_ready2;

    // WIDTH=32, NCH=32 instance
    logic          mode32, out_valid32, out_ready32;
    logic [4:0]    sel32, out_ch32;
    logic [1023:0] in_data32;
    logic [31:0]   in_valid32, in_ready32, out_data32;

    rr_mux_arb #(.WIDTH(8), .NCH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode8), .sel(sel8), .in_data(in_data8),
        .in_valid(in_valid8), .in_ready(in_ready8), .out_data(out_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_ch(out_ch8));

    rr_mux_arb #(.WIDTH(8), .NCH(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .mode(mode6), .sel(sel6), .in_data(in_data6),
        .in_valid(in_valid6), .in_ready(in_ready6), .out_data(out_data6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_ch(out_ch6));

    rr_mux_arb #(.WIDTH(1), .NCH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode2), .sel(sel2), .in_data(in_data2),
        .in_valid(in_valid2), .in_ready(in_ready2), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_ch(out_ch2));

    rr_mux_arb #(.WIDTH(32), .NCH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .mode(mode32), .sel(sel32), .in_data(in_data32),
        .in_valid(in_valid32), .in_ready(in_ready32), .out_data(out_data32),
        .out_valid(out_valid32), .out_ready(out_ready32), .out_ch(out_ch32));

    // ---------------- scoreboard / checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [31:0] v, input int p, input int n);
        int c;
        for (int i = 0; i < n; i++) begin
            c = (p + i) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Random valid/ready/data on one sized instance, checked against a reference queue.
    task automatic sweep(input int n, input int cycles);
        int          mptr;
        int          g;
        logic        mov;
        logic        rr;
        logic [31:0] vv;
        logic [31:0] dd[32];
        logic [31:0] exp_rdy, got_rdy, got_d;
        logic [4:0]  got_ch;
        logic [36:0] e;
        mptr = 0;
        mov  = 1'b0;
        exp_q.delete();
        step();
        for (int c = 0; c < cycles + 2; c++) begin
            vv = (c >= cycles) ? 32'd0 : ($urandom & $urandom);
            if (n == 2) vv = (c >= cycles) ? 32'd0 : 32'($urandom_range(0, 3));
            rr = (c >= cycles) ? 1'b1 : ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 32; k++) begin
                dd[k] = $urandom;
                if (n == 2) dd[k] = dd[k] & 32'd1;
            end
            if (n == 32) begin
                in_valid32  = vv;
                out_ready32 = rr;
                for (int k = 0; k < 32; k++) in_data32[k*32 +: 32] = dd[k];
            end else begin
                in_valid2  = vv[1:0];
                out_ready2 = rr;
                for (int k = 0; k < 2; k++) in_data2[k] = dd[k][0];
            end
            #1;
            got_rdy = (n == 32) ? in_ready32 : {30'd0, in_ready2};
            got_ch  = (n == 32) ? out_ch32 : {4'd0, out_ch2};
            got_d   = (n == 32) ? out_data32 : {31'd0, out_data2};
            g = rr_pick(vv, mptr, n);
            exp_rdy = ((!mov || rr) && g >= 0) ? (32'd1 << g) : 32'd0;
            check((n == 32) ? "sweep32_in_ready" : "sweep2_in_ready", 64'(got_rdy), 64'(exp_rdy));
            if (mov && rr) begin
                check("sweep_sb_depth", 64'(exp_q.size()), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check((n == 32) ? "sweep32_word" : "sweep2_word", 64'({got_ch, got_d}), 64'(e));
                end
            end
            if (!mov || rr) begin
                mov = (g >= 0);
                if (g >= 0) begin
                    exp_q.push_back({5'(g), dd[g]});
                    mptr = (g + 1) % n;
                end
            end
            step();
            check((n == 32) ? "sweep32_out_valid" : "sweep2_out_valid",
                  64'((n == 32) ? out_valid32 : out_valid2), 64'(mov));
        end
        check("sweep_sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        mode8 = 1'b1; sel8 = 3'd0; in_valid8 = 8'hFF; out_ready8 = 1'b1;
        for (int k = 0; k < 8; k++) in_data8[k*8 +: 8] = 8'(8'hA0 + k);
        mode6 = 1'b0; sel6 = 3'd7; in_valid6 = 6'h3F; out_ready6 = 1'b1;
        for (int k = 0; k < 6; k++) in_data6[k*8 +: 8] = 8'(8'h60 + k);
        mode2 = 1'b1; sel2 = 1'b0; in_valid2 = 2'b00; out_ready2 = 1'b1; in_data2 = 2'b00;
        mode32 = 1'b1; sel32 = 5'd0; in_valid32 = 32'd0; out_ready32 = 1'b1; in_data32 = '0;

        // reset state, with requests already pending
        #3;
        check("rst_out_valid", 64'(out_valid8), 64'd0);
        check("rst_out_data", 64'(out_data8), 64'd0);
        check("rst_out_ch", 64'(out_ch8), 64'd0);
        check("rst_in_ready", 64'(in_ready8), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("rel_in_ready", 64'(in_ready8), 64'h01);

        // fairness: all valid -> 0..7,0 one per cycle
        for (int k = 1; k <= 9; k++) begin
            step();
            check("fair_out_ch", 64'(out_ch8), 64'((k - 1) % 8));
            check("fair_out_data", 64'(out_data8), 64'(8'hA0 + (k - 1) % 8));
            check("fair_out_valid", 64'(out_valid8), 64'd1);
            check("fair_in_ready", 64'(in_ready8), 64'(8'd1 << (k % 8)));
        end

        // steer ptr to 3 with channel 2 alone, then skip pattern 7,2,7
        in_valid8 = 8'h04;
        #1 check("skip_prep_rdy", 64'(in_ready8), 64'h04);
        step();
        check("skip_prep_ch", 64'(out_ch8), 64'd2);
        in_valid8 = 8'b1000_0100;
        #1 check("skip_rdy_a", 64'(in_ready8), 64'h80);
        step();
        check("skip_ch_a", 64'(out_ch8), 64'd7);
        check("skip_data_a", 64'(out_data8), 64'hA7);
        check("skip_rdy_b", 64'(in_ready8), 64'h04);
        step();
        check("skip_ch_b", 64'(out_ch8), 64'd2);
        check("skip_rdy_c", 64'(in_ready8), 64'h80);
        step();
        check("skip_ch_c", 64'(out_ch8), 64'd7);

        // backpressure: hold for 5 cycles, then load on release edge
        out_ready8 = 1'b0;
        in_valid8  = 8'hFF;
        #1 check("bp_in_ready", 64'(in_ready8), 64'h00);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_out_ch", 64'(out_ch8), 64'd7);
            check("bp_out_data", 64'(out_data8), 64'hA7);
            check("bp_out_valid", 64'(out_valid8), 64'd1);
            check("bp_hold_rdy", 64'(in_ready8), 64'h00);
        end
        out_ready8 = 1'b1;
        #1 check("bp_release_rdy", 64'(in_ready8), 64'h01);
        step();
        check("bp_next_ch", 64'(out_ch8), 64'd0);
        check("bp_next_data", 64'(out_data8), 64'hA0);

        // drain with no requests: valid falls, data/ch hold
        in_valid8 = 8'h00;
        step();
        check("drain_out_valid", 64'(out_valid8), 64'd0);
        check("drain_out_data", 64'(out_data8), 64'hA0);
        check("drain_out_ch", 64'(out_ch8), 64'd0);
        step();
        check("idle_out_valid", 64'(out_valid8), 64'd0);

        // fixed mode: only sel granted, ptr untouched
        mode8 = 1'b0; sel8 = 3'd5; in_valid8 = 8'hFF;
        #1 check("fix_in_ready", 64'(in_ready8), 64'h20);
        step();
        check("fix_out_ch", 64'(out_ch8), 64'd5);
        check("fix_out_data", 64'(out_data8), 64'hA5);
        check("fix_in_ready2", 64'(in_ready8), 64'h20);
        in_valid8 = 8'hDF;
        #1 check("fix_novalid_rdy", 64'(in_ready8), 64'h00);
        step();
        check("fix_novalid_ov", 64'(out_valid8), 64'd0);
        mode8 = 1'b1; in_valid8 = 8'hFF;
        #1 check("fix_ptr_kept", 64'(in_ready8), 64'h02);
        step();
        check("rr_resume_ch", 64'(out_ch8), 64'd1);

        // reset mid-stream: asynchronous clear, restart from channel 0
        #3 rst_n = 1'b0;
        #1;
        check("mrst_out_valid", 64'(out_valid8), 64'd0);
        check("mrst_out_data", 64'(out_data8), 64'd0);
        check("mrst_out_ch", 64'(out_ch8), 64'd0);
        check("mrst_in_ready", 64'(in_ready8), 64'h00);
        step();
        check("mrst_hold_ov", 64'(out_valid8), 64'd0);
        rst_n = 1'b1;
        #1 check("mrst_rel_rdy", 64'(in_ready8), 64'h01);
        step();
        check("mrst_first_ch", 64'(out_ch8), 64'd0);
        check("mrst_first_data", 64'(out_data8), 64'hA0);
        check("mrst_first_ov", 64'(out_valid8), 64'd1);

        // NCH=6: sel out of range grants nothing
        #1 check("n6_sel7_rdy", 64'(in_ready6), 64'h00);
        step();
        check("n6_sel7_ov", 64'(out_valid6), 64'd0);
        sel6 = 3'd6;
        #1 check("n6_sel6_rdy", 64'(in_ready6), 64'h00);
        sel6 = 3'd3;
        #1 check("n6_sel3_rdy", 64'(in_ready6), 64'h08);
        step();
        check("n6_sel3_ch", 64'(out_ch6), 64'd3);
        check("n6_sel3_data", 64'(out_data6), 64'h63);

        // width/depth sweep
        in_valid8 = 8'h00;
        in_valid6 = 6'h00;
        sweep(2, 300);
        sweep(32, 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
